// File: rtl/opnd_writeback_pkg.sv
// Shared encodings for the operand write-back path: destination kinds,
// register selectors and the write-back state encoding.
package opnd_writeback_pkg;

    localparam logic [1:0] OPND_DEST_NONE     = 2'b00;
    localparam logic [1:0] OPND_DEST_REG_1HOT = 2'b01;
    localparam logic [1:0] OPND_DEST_MEM_1HOT = 2'b10;

    localparam logic [2:0] REG_EAX = 3'd0;
    localparam logic [2:0] REG_ECX = 3'd1;
    localparam logic [2:0] REG_EDX = 3'd2;
    localparam logic [2:0] REG_EBX = 3'd3;
    localparam logic [2:0] REG_ESP = 3'd4;
    localparam logic [2:0] REG_EBP = 3'd5;
    localparam logic [2:0] REG_ESI = 3'd6;
    localparam logic [2:0] REG_EDI = 3'd7;

    typedef enum logic [1:0] {
        WB_ST_IDLE = 2'd0,
        WB_ST_WB0  = 2'd1,
        WB_ST_WB1  = 2'd2,
        WB_ST_DONE = 2'd3
    } wb_state_t;

    // Both kind bits set is not a legal encoding; it retires nothing.
    function automatic logic [1:0] norm_kind(input logic [1:0] kind);
        return (kind == 2'b11) ? OPND_DEST_NONE : kind;
    endfunction

endpackage

// File: rtl/opnd_writeback_hint_match.sv
// wb_hint_match: combinational test of one memory destination against the
// two write hints; each match excludes hints already consumed in the bundle.
module wb_hint_match #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] cmp_mask,
    input  logic              hint1_is_write,
    input  logic [DATA_W-1:0] hint1_address,
    input  logic [DATA_W-1:0] hint1_data,
    input  logic              hint1_used,
    input  logic              hint2_is_write,
    input  logic [DATA_W-1:0] hint2_address,
    input  logic [DATA_W-1:0] hint2_data,
    input  logic              hint2_used,
    output logic              match1,
    output logic              match2
);

    assign match1 = hint1_is_write && !hint1_used && (hint1_address == addr) &&
                    (((hint1_data ^ data) & cmp_mask) == '0);
    assign match2 = hint2_is_write && !hint2_used && (hint2_address == addr) &&
                    (((hint2_data ^ data) & cmp_mask) == '0);

endmodule

// File: rtl/opnd_writeback_size_align.sv
// wb_size_align: maps operand size flags, selector and result onto the
// register-file byte lanes, plus the data compare mask used by hint checks.
module wb_size_align #(
    parameter int DATA_W   = 32,
    parameter int REGSEL_W = 3
) (
    input  logic                byte1,
    input  logic                w16,
    input  logic [REGSEL_W-1:0] sel,
    input  logic [DATA_W-1:0]   result,
    output logic [REGSEL_W-1:0] wsel,
    output logic [3:0]          mask,
    output logic [DATA_W-1:0]   data,
    output logic [DATA_W-1:0]   cmp_mask
);

    always_comb begin
        wsel     = sel;
        mask     = 4'b1111;
        data     = result;
        cmp_mask = '1;
        if (byte1) begin
            cmp_mask = {{(DATA_W-8){1'b0}}, 8'hFF};
            if (sel[REGSEL_W-1]) begin
                // AH/CH/DH/BH live in byte 1 of the low four registers
                wsel = {1'b0, sel[REGSEL_W-2:0]};
                mask = 4'b0010;
                data = {{(DATA_W-16){1'b0}}, result[7:0], 8'h00};
            end else begin
                mask = 4'b0001;
                data = {{(DATA_W-8){1'b0}}, result[7:0]};
            end
        end else if (w16) begin
            cmp_mask = {{(DATA_W-16){1'b0}}, 16'hFFFF};
            mask     = 4'b0011;
            data     = {{(DATA_W-16){1'b0}}, result[15:0]};
        end
    end

endmodule

// File: rtl/opnd_writeback.sv
// Operand write-back: retires dest0 then dest1 into the register file or
// checks memory destinations against write hints (OPND_WB_HINT_CHECK_EN).
module opnd_writeback
    import opnd_writeback_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REGSEL_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          dest0_kind,
    input  logic [1:0]          dest1_kind,
    input  logic [DATA_W-1:0]   dest0_sel,
    input  logic [DATA_W-1:0]   dest1_sel,
    input  logic [DATA_W-1:0]   dest0_addr,
    input  logic [DATA_W-1:0]   dest1_addr,
    input  logic [DATA_W-1:0]   result0,
    input  logic [DATA_W-1:0]   result1,
    input  logic                reg_1byte,
    input  logic                prefix_operand_16bit,
    input  logic                hint1_is_write,
    input  logic [DATA_W-1:0]   hint1_address,
    input  logic [DATA_W-1:0]   hint1_data,
    input  logic                hint2_is_write,
    input  logic [DATA_W-1:0]   hint2_address,
    input  logic [DATA_W-1:0]   hint2_data,
    output logic                reg_we,
    output logic [REGSEL_W-1:0] reg_wsel,
    output logic [3:0]          reg_wmask,
    output logic [DATA_W-1:0]   reg_wdata,
    output logic                wb_done,
    output logic                hint_violation
);

    wb_state_t state, next_state;

    logic [1:0]          k0_in, k1_in, k1_q;
    logic [REGSEL_W-1:0] sel1_q;
    logic [DATA_W-1:0]   res1_q, addr1_q;
    logic                b1_q, w16_q;
    logic                accept;

    logic                retire;
    logic [1:0]          cur_kind;
    logic [REGSEL_W-1:0] cur_sel;
    logic [DATA_W-1:0]   cur_res, cur_addr;
    logic                cur_b1, cur_w16;

    logic [REGSEL_W-1:0] al_wsel;
    logic [3:0]          al_mask;
    logic [DATA_W-1:0]   al_data, al_cmp_mask;

    assign k0_in  = norm_kind(dest0_kind);
    assign k1_in  = norm_kind(dest1_kind);
    assign accept = (state == WB_ST_IDLE) && in_valid;

    logic unused_sel_hi;
    assign unused_sel_hi = ^{dest0_sel[DATA_W-1:REGSEL_W], dest1_sel[DATA_W-1:REGSEL_W]};

    // The destination retired in the next cycle is picked here, so the
    // registered write port lines up with the WB0/WB1 state it belongs to.
    always_comb begin
        next_state = state;
        retire     = 1'b0;
        cur_kind   = OPND_DEST_NONE;
        cur_sel    = sel1_q;
        cur_res    = res1_q;
        cur_addr   = addr1_q;
        cur_b1     = b1_q;
        cur_w16    = w16_q;
        case (state)
            WB_ST_IDLE: begin
                cur_b1  = reg_1byte;
                cur_w16 = prefix_operand_16bit;
                if (in_valid) begin
                    if (k0_in != OPND_DEST_NONE) begin
                        retire     = 1'b1;
                        cur_kind   = k0_in;
                        cur_sel    = dest0_sel[REGSEL_W-1:0];
                        cur_res    = result0;
                        cur_addr   = dest0_addr;
                        next_state = WB_ST_WB0;
                    end else if (k1_in != OPND_DEST_NONE) begin
                        retire     = 1'b1;
                        cur_kind   = k1_in;
                        cur_sel    = dest1_sel[REGSEL_W-1:0];
                        cur_res    = result1;
                        cur_addr   = dest1_addr;
                        next_state = WB_ST_WB1;
                    end else begin
                        next_state = WB_ST_DONE;
                    end
                end
            end
            WB_ST_WB0: begin
                if (k1_q != OPND_DEST_NONE) begin
                    retire     = 1'b1;
                    cur_kind   = k1_q;
                    next_state = WB_ST_WB1;
                end else begin
                    next_state = WB_ST_DONE;
                end
            end
            WB_ST_WB1:  next_state = WB_ST_DONE;
            default:    next_state = WB_ST_IDLE;
        endcase
    end

    wb_size_align #(.DATA_W(DATA_W), .REGSEL_W(REGSEL_W)) u_size_align (
        .byte1    (cur_b1),
        .w16      (cur_w16),
        .sel      (cur_sel),
        .result   (cur_res),
        .wsel     (al_wsel),
        .mask     (al_mask),
        .data     (al_data),
        .cmp_mask (al_cmp_mask)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WB_ST_IDLE;
            in_ready  <= 1'b1;
            reg_we    <= 1'b0;
            reg_wsel  <= '0;
            reg_wmask <= '0;
            reg_wdata <= '0;
            wb_done   <= 1'b0;
            k1_q      <= OPND_DEST_NONE;
        end else begin
            state     <= next_state;
            in_ready  <= (next_state == WB_ST_IDLE);
            wb_done   <= (next_state == WB_ST_DONE);
            reg_we    <= 1'b0;
            reg_wsel  <= '0;
            reg_wmask <= '0;
            reg_wdata <= '0;
            if (retire && (cur_kind == OPND_DEST_REG_1HOT)) begin
                reg_we    <= 1'b1;
                reg_wsel  <= al_wsel;
                reg_wmask <= al_mask;
                reg_wdata <= al_data;
            end
            if (accept) k1_q <= k1_in;
        end
    end

    // Bundle payload: captured on accept, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            sel1_q  <= dest1_sel[REGSEL_W-1:0];
            res1_q  <= result1;
            addr1_q <= dest1_addr;
            b1_q    <= reg_1byte;
            w16_q   <= prefix_operand_16bit;
        end
    end

`ifdef OPND_WB_HINT_CHECK_EN
    logic              h1w_q, h2w_q, used1_q, used2_q, match1, match2;
    logic [DATA_W-1:0] h1a_q, h1d_q, h2a_q, h2d_q;
    logic              idle;

    assign idle = (state == WB_ST_IDLE);

    always_ff @(posedge clk) begin
        if (accept) begin
            h1w_q <= hint1_is_write;
            h1a_q <= hint1_address;
            h1d_q <= hint1_data;
            h2w_q <= hint2_is_write;
            h2a_q <= hint2_address;
            h2d_q <= hint2_data;
        end
    end

    wb_hint_match #(.DATA_W(DATA_W)) u_hint_match (
        .addr           (cur_addr),
        .data           (cur_res),
        .cmp_mask       (al_cmp_mask),
        .hint1_is_write (idle ? hint1_is_write : h1w_q),
        .hint1_address  (idle ? hint1_address  : h1a_q),
        .hint1_data     (idle ? hint1_data     : h1d_q),
        .hint1_used     (idle ? 1'b0           : used1_q),
        .hint2_is_write (idle ? hint2_is_write : h2w_q),
        .hint2_address  (idle ? hint2_address  : h2a_q),
        .hint2_data     (idle ? hint2_data     : h2d_q),
        .hint2_used     (idle ? 1'b0           : used2_q),
        .match1         (match1),
        .match2         (match2)
    );

    // The first hint wins when both match, leaving the other free for a second store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            used1_q        <= 1'b0;
            used2_q        <= 1'b0;
            hint_violation <= 1'b0;
        end else begin
            if (accept) begin
                used1_q <= 1'b0;
                used2_q <= 1'b0;
            end
            if (retire && (cur_kind == OPND_DEST_MEM_1HOT)) begin
                if (match1)      used1_q        <= 1'b1;
                else if (match2) used2_q        <= 1'b1;
                else             hint_violation <= 1'b1;
            end
        end
    end
`else
    assign hint_violation = 1'b0;

    logic unused_hint;
    assign unused_hint = ^{cur_addr, al_cmp_mask, hint1_is_write, hint1_address, hint1_data,
                           hint2_is_write, hint2_address, hint2_data};
`endif

endmodule
